// File: rtl/bsg_flow_pkg.sv
// Shared definitions for the credit/ready flow converters and their credit senders.
package bsg_flow_pkg;

  // Largest supported buffer depth (and therefore initial credit count).
  localparam int unsigned MaxEls = 64;

  // Bits needed to hold a credit count or an occupancy in the range 0..els.
  function automatic int unsigned credit_width(int unsigned els);
    return $clog2(els + 1);
  endfunction

  localparam int unsigned MaxCountW = credit_width(MaxEls);

  // Flow-side status as seen by the credit sender.
  typedef struct packed {
    logic [MaxCountW-1:0] count;
    logic                 overflow;
  } flow_status_t;

endpackage

// File: rtl/bsg_flow_credit_fifo_core.sv
// Register-array storage with wrapping read/write pointers. Flow control
// (full/empty decisions) lives in the parent; this block only obeys enq/deq.
module bsg_flow_credit_fifo_core #(
  parameter int unsigned width_p = 16,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic               deq_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(els_p - 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq_i) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (deq_i) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/bsg_credit_to_ready_flow_converter.sv
// Converts a credit-based sender into a valid/ready consumer interface.
// Each dequeue returns one credit one cycle later; writes that arrive with no
// room are dropped and latched in a sticky overflow flag.
module bsg_credit_to_ready_flow_converter
  import bsg_flow_pkg::*;
#(
  parameter int unsigned width_p = 16,
  parameter int unsigned els_p   = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             credit_o,
  output logic                             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             ready_i,
  output logic [credit_width(els_p)-1:0]   count_o,
  output logic                             overflow_o
);

  localparam int unsigned CountW = credit_width(els_p);
  localparam logic [CountW-1:0] FullCount = CountW'(els_p);

  logic [CountW-1:0] count_q, count_d;
  logic              credit_q;
  logic              overflow_q, overflow_d;
  logic              full, enq, deq;

  assign full = (count_q == FullCount);
  assign v_o  = (count_q != '0);
  assign deq  = v_o & ready_i;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign enq  = v_i & (~full | deq);

  // Occupancy and sticky overflow next-state.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (v_i & full & ~deq);
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops occupancy, any pending credit and the flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      credit_q   <= deq;
      overflow_q <= overflow_d;
    end
  end

  assign credit_o   = credit_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  bsg_flow_credit_fifo_core #(
    .width_p(width_p),
    .els_p  (els_p)
  ) u_core (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .enq_i    (enq),
    .deq_i    (deq),
    .data_i   (data_i),
    .data_o   (data_o)
  );

endmodule

// File: tb/tb_bsg_credit_to_ready_flow_converter.sv
module tb_bsg_credit_to_ready_flow_converter;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        credit_o;
  logic        v_o;
  logic [15:0] data_o;
  logic        ready_i = 1'b0;
  logic [2:0]  count_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_credit_to_ready_flow_converter #(
    .width_p(16),
    .els_p  (4)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .credit_o  (credit_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .count_o   (count_o),
    .overflow_o(overflow_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    v_i = 1'b0;
    ready_i = 1'b0;
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({v_o, credit_o, count_o, overflow_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b cr=%b cnt=%0d ov=%b exp all 0",
               v_o, credit_o, count_o, overflow_o);
    end
  endtask

  task automatic test_single();
    apply_reset();
    v_i = 1'b1; data_i = 16'hA5A5;
    step();
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b1 || data_o !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_data got v=%b d=%h exp v=1 d=a5a5", v_o, data_o);
    end
    checks++;
    if (count_o !== 3'd1) begin
      errors++;
      $display("FAIL single_count got %0d exp 1", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (credit_o !== 1'b0) begin
        errors++;
        $display("FAIL single_no_credit cycle %0d got %b exp 0", i, credit_o);
      end
      step();
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      v_i = 1'b1; data_i = 16'(i);
      step();
      checks++;
      if (count_o !== 3'(i) || credit_o !== 1'b0) begin
        errors++;
        $display("FAIL fill_count got cnt=%0d cr=%b exp cnt=%0d cr=0", count_o, credit_o, i);
      end
    end
    v_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (v_o !== 1'b1 || data_o !== 16'(i + 1)) begin
        errors++;
        $display("FAIL drain_order got v=%b d=%h exp v=1 d=%h", v_o, data_o, 16'(i + 1));
      end
      step();
      checks++;
      if (credit_o !== 1'b1 || count_o !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain_credit got cr=%b cnt=%0d exp cr=1 cnt=%0d", credit_o, count_o, 3 - i);
      end
    end
    ready_i = 1'b0;
    step();
    checks++;
    if (credit_o !== 1'b0 || v_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got cr=%b v=%b exp 0 0", credit_o, v_o);
    end
  endtask

  // Leaves the buffer full holding 0x11..0x14 for test_overflow.
  task automatic test_full_simul();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; data_i = 16'h0010 + 16'(i);
      step();
    end
    checks++;
    if (count_o !== 3'd4 || data_o !== 16'h0010) begin
      errors++;
      $display("FAIL full_setup got cnt=%0d d=%h exp 4 0010", count_o, data_o);
    end
    data_i = 16'h0014; ready_i = 1'b1;
    step();
    v_i = 1'b0; ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b0 || credit_o !== 1'b1) begin
      errors++;
      $display("FAIL full_simul got cnt=%0d ov=%b cr=%b exp 4 0 1", count_o, overflow_o, credit_o);
    end
    step();
    checks++;
    if (credit_o !== 1'b0 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL full_simul_after got cr=%b cnt=%0d exp 0 4", credit_o, count_o);
    end
  endtask

  task automatic test_overflow();
    v_i = 1'b1; data_i = 16'hDEAD; ready_i = 1'b0;
    step();
    v_i = 1'b0;
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got cnt=%0d ov=%b exp 4 1", count_o, overflow_o);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b exp 1", overflow_o);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_o !== 16'h0011 + 16'(i)) begin
        errors++;
        $display("FAIL overflow_contents got %h exp %h", data_o, 16'h0011 + 16'(i));
      end
      step();
    end
    ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drained got cnt=%0d ov=%b exp 0 1", count_o, overflow_o);
    end
  endtask

  task automatic test_back_to_back();
    int credits;
    int next_head;
    credits = 0;
    next_head = 0;
    apply_reset();
    v_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_i = 16'(i);
      if (v_o) begin
        checks++;
        if (data_o !== 16'(next_head)) begin
          errors++;
          $display("FAIL stream_order cycle %0d got %h exp %h", i, data_o, 16'(next_head));
        end
        next_head++;
      end
      step();
      if (credit_o === 1'b1) credits++;
    end
    v_i = 1'b0; ready_i = 1'b0;
    checks++;
    if (credits != 99) begin
      errors++;
      $display("FAIL stream_credits got %0d exp 99", credits);
    end
    checks++;
    if (next_head != 99) begin
      errors++;
      $display("FAIL stream_deq_count got %0d exp 99", next_head);
    end
    checks++;
    if (overflow_o !== 1'b0 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL stream_end got ov=%b cnt=%0d exp 0 1", overflow_o, count_o);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; data_i = 16'h0100 + 16'(i);
      step();
    end
    v_i = 1'b0; ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++;
    if (count_o !== 3'd3 || credit_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup got cnt=%0d cr=%b exp 3 1", count_o, credit_o);
    end
    #1 reset_n_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || credit_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL midreset_async got v=%b cr=%b cnt=%0d exp 0 0 0", v_o, credit_o, count_o);
    end
    step();
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (v_o !== 1'b0 || credit_o !== 1'b0 || count_o !== 3'd0) begin
        errors++;
        $display("FAIL midreset_after got v=%b cr=%b cnt=%0d exp 0 0 0", v_o, credit_o, count_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
